spi_master: RTL and testbench

Single-lane SPI master that drives the SPI slave/RAM subsystem from the system side. It accepts one command at a time over a valid/ready handshake and serialises a 10-bit frame, command bits then payload, onto MOSI under SS_n. For read-data commands it captures the 8-bit reply from MISO and returns it with a one-cycle strobe. SCK is the shared system clock `clk`: MOSI/SS_n launch on posedge, and the slave samples on the next posedge.

---
 rtl/spi_master_if.sv | 22 ++
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Command handshake bundle for spi_master.
// The system side issues commands; spi_master consumes them.
interface spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/spi_master.sv
// Single-lane SPI master: one 10-bit frame per command,
// with an 8-bit MISO reply captured for read-data commands.
module spi_master #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_master_if.slave bus,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       seq_err,
  output logic       busy
);

  localparam int CW = (RD_WAIT > 8) ? $clog2(RD_WAIT) : 4;

  typedef enum logic [2:0] {
    IDLE, CMD, SHIFT, TAIL, WAIT, RECV, GAP
  } state_e;

  state_e        state_q;
  logic [9:0]    frame_q;
  logic [CW-1:0] cnt_q;
  logic          rd_q;
  logic          flag_q;
  logic [6:0]    shreg_q;
  logic          ss_n_q;
  logic          mosi_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          seq_err_q;
  logic          accept;

  assign accept        = (state_q == IDLE) & bus.cmd_valid;
  assign bus.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign seq_err       = seq_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      flag_q     <= 1'b0;
      shreg_q    <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= CMD;
            frame_q <= {bus.cmd_type, bus.cmd_data};
            rd_q    <= (bus.cmd_type == 2'b11);
            ss_n_q  <= 1'b0;
            mosi_q  <= bus.cmd_type[1];
            // Read-data must follow a read-addr; frame still goes out.
            if (bus.cmd_type == 2'b11) begin
              seq_err_q <= ~flag_q;
              flag_q    <= 1'b0;
            end else if (bus.cmd_type == 2'b10) begin
              flag_q <= 1'b1;
            end
          end
        end
        CMD: begin
          state_q <= SHIFT;
          cnt_q   <= CW'(9);
          mosi_q  <= frame_q[9];
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            mosi_q <= 1'b0;
            if (rd_q) begin
              state_q <= WAIT;
              cnt_q   <= CW'(RD_WAIT - 1);
            end else begin
              state_q <= TAIL;
            end
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            mosi_q  <= frame_q[8];
            frame_q <= {frame_q[8:0], 1'b0};
          end
        end
        TAIL: begin
          state_q <= GAP;
          ss_n_q  <= 1'b1;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RECV;
            cnt_q   <= CW'(7);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RECV: begin
          shreg_q <= {shreg_q[5:0], MISO};
          if (cnt_q == '0) begin
            state_q    <= GAP;
            ss_n_q     <= 1'b1;
            rd_data_q  <= {shreg_q, MISO};
            rd_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of frames
// plus back-to-back, mid-frame reset and RD_WAIT=4 cases.
module tb_spi_master;

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  dat;
    logic [7:0]  miso_b;
    logic [10:0] mosi;
    logic        seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = '0;
  logic [7:0] cmd_data = '0;
  logic       miso = 1'b0;
  logic       sel = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] last_rd [2];

  spi_master_if bus2 ();
  spi_master_if bus4 ();

  logic       ss2, mosi2, rdv2, se2, busy2;
  logic       ss4, mosi4, rdv4, se4, busy4;
  logic [7:0] rd2, rd4;

  assign bus2.cmd_valid = cmd_valid & ~sel;
  assign bus2.cmd_type  = cmd_type;
  assign bus2.cmd_data  = cmd_data;
  assign bus4.cmd_valid = cmd_valid & sel;
  assign bus4.cmd_type  = cmd_type;
  assign bus4.cmd_data  = cmd_data;

  spi_master #(.RD_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .SS_n(ss2), .MOSI(mosi2), .MISO(miso & ~sel),
    .rd_data(rd2), .rd_valid(rdv2), .seq_err(se2),
    .busy(busy2)
  );

  spi_master #(.RD_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .SS_n(ss4), .MOSI(mosi4), .MISO(miso & sel),
    .rd_data(rd4), .rd_valid(rdv4), .seq_err(se4),
    .busy(busy4)
  );

  logic       ss, mo, rdv, se, bsy, rdy;
  logic [7:0] rdd;
  assign ss  = sel ? ss4 : ss2;
  assign mo  = sel ? mosi4 : mosi2;
  assign rdv = sel ? rdv4 : rdv2;
  assign se  = sel ? se4 : se2;
  assign bsy = sel ? busy4 : busy2;
  assign rdy = sel ? bus4.cmd_ready : bus2.cmd_ready;
  assign rdd = sel ? rd4 : rd2;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int k,
                     logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h want=%h",
               nm, k, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("ready_wait", n, 16'(rdy), 16'(1));
  endtask

  task automatic run_vec(vec_t v, int rw);
    int   g;
    logic rd;
    rd = (v.typ == 2'b11);
    g  = rd ? 20 + rw : 13;
    wait_ready();
    cmd_type  = v.typ;
    cmd_data  = v.dat;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_type  = ~v.typ;
    cmd_data  = ~v.dat;
    for (int k = 1; k <= g; k++) begin
      if (rd && k >= g - 8 && k <= g - 1)
        miso = v.miso_b[g - 1 - k];
      else
        miso = 1'b0;
      chk("ss_n", k, 16'(ss), 16'(k == g));
      chk("mosi", k, 16'(mo),
          16'(k <= 11 ? v.mosi[11 - k] : 1'b0));
      chk("ready", k, 16'(rdy), 16'(0));
      chk("busy", k, 16'(bsy), 16'(1));
      chk("rd_valid", k, 16'(rdv), 16'(rd && k == g));
      chk("seq_err", k, 16'(se), 16'(k == 1 && v.seq));
      if (k == 1)
        chk("rd_hold", k, 16'(rdd), 16'(last_rd[sel]));
      if (rd && k == g) begin
        chk("rd_data", k, 16'(rdd), 16'(v.miso_b));
        last_rd[sel] = v.miso_b;
      end
      step();
    end
    miso = 1'b0;
    chk("ready_end", g + 1, 16'(rdy), 16'(1));
    chk("ss_n_end", g + 1, 16'(ss), 16'(1));
  endtask

  vec_t tbl [6];
  vec_t v;

  initial begin
    tbl[0] = '{2'b11, 8'h00, 8'h96, 11'b11100000000, 1'b1};
    tbl[1] = '{2'b00, 8'h5A, 8'h00, 11'b00001011010, 1'b0};
    tbl[2] = '{2'b10, 8'h3C, 8'h00, 11'b11000111100, 1'b0};
    tbl[3] = '{2'b01, 8'hC3, 8'h00, 11'b00111000011, 1'b0};
    tbl[4] = '{2'b11, 8'h00, 8'hA5, 11'b11100000000, 1'b0};
    tbl[5] = '{2'b11, 8'hFF, 8'h3C, 11'b11111111111, 1'b1};
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_ss_n", 0, 16'(ss2), 16'(1));
    chk("rst_mosi", 0, 16'(mosi2), 16'(0));
    chk("rst_ready", 0, 16'(bus2.cmd_ready), 16'(1));
    chk("rst_busy", 0, 16'(busy2), 16'(0));
    chk("rst_rdv", 0, 16'(rdv2), 16'(0));
    chk("rst_seq", 0, 16'(se2), 16'(0));
    chk("rst_rd", 0, 16'(rd2), 16'(0));
    chk("rst_ss4", 0, 16'(ss4), 16'(1));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i], 2);

    // Back-to-back 01 with cmd_valid held high
    wait_ready();
    cmd_type  = 2'b01;
    cmd_data  = 8'h81;
    cmd_valid = 1'b1;
    begin
      int acc;
      acc = 0;
      for (int c = 0; c <= 42; c++) begin
        if (rdy) acc++;
        chk("b2b_ready", c, 16'(rdy), 16'(c % 14 == 0));
        chk("b2b_busy", c, 16'(bsy), 16'(c % 14 != 0));
        chk("b2b_ss_n", c, 16'(ss),
            16'(c % 14 == 0 || c % 14 == 13));
        step();
      end
      chk("b2b_count", 0, 16'(acc), 16'(4));
    end
    cmd_valid = 1'b0;
    wait_ready();

    // Reset during the shift of a 00 frame
    cmd_type  = 2'b00;
    cmd_data  = 8'h5A;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k < 6; k++) step();
    chk("mid_ss_low", 6, 16'(ss2), 16'(0));
    rst_n = 1'b0;
    step();
    chk("mid_ss_n", 7, 16'(ss2), 16'(1));
    chk("mid_mosi", 7, 16'(mosi2), 16'(0));
    chk("mid_ready", 7, 16'(bus2.cmd_ready), 16'(1));
    chk("mid_rdv", 7, 16'(rdv2), 16'(0));
    chk("mid_rd", 7, 16'(rd2), 16'(0));
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    step();
    chk("mid_rdv2", 8, 16'(rdv2), 16'(0));
    run_vec(tbl[1], 2);

    // RD_WAIT=4 instance
    sel = 1'b1;
    v = '{2'b10, 8'h3C, 8'h00, 11'b11000111100, 1'b0};
    run_vec(v, 4);
    v = '{2'b11, 8'h00, 8'hFF, 11'b11100000000, 1'b0};
    run_vec(v, 4);
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
